// File: rtl/bist_pkg.sv
// Shared definitions for the AND-gate BIST loop: controller states, default
// signature geometry and the golden CUT response.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SIG_W_DEF = 8;
  localparam logic [7:0]  POLY_DEF  = 8'h1D;
  localparam int unsigned CNT_W_DEF = 4;

  function automatic logic and_gold(input logic [1:0] pat);
    return pat[1] & pat[0];
  endfunction

endpackage

// File: rtl/ora_and_sisr_if.sv
// Pattern/response and status bundle between TPG/CUT, ORA and BIST controller.
interface ora_and_sisr_if
  import bist_pkg::*;
#(
  parameter int unsigned SIG_W = SIG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             start;
  logic [1:0]       pat;
  logic             cut_out;
  logic             pat_valid;
  logic [CNT_W-1:0] num_pat;
  logic [SIG_W-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, pat, cut_out, pat_valid, num_pat, golden_sig,
    input  busy, done, pass, signature, err_cnt
  );

  modport slave (
    input  start, pat, cut_out, pat_valid, num_pat, golden_sig,
    output busy, done, pass, signature, err_cnt
  );
endinterface

// File: rtl/sisr_reg.sv
// Serial-input signature register: shifts left, folds POLY back in when the
// MSB falls out, and XORs the serial bit into the LSB.
module sisr_reg #(
  parameter int unsigned      SIG_W    = 8,
  parameter logic [SIG_W-1:0] POLY     = 8'h1D,
  parameter logic [SIG_W-1:0] SIG_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SIG_INIT;
    end else if (clear) begin
      sig <= SIG_INIT;
    end else if (shift) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ (sig[SIG_W-1] ? POLY : '0)
           ^ {{(SIG_W-1){1'b0}}, din};
    end
  end

endmodule

// File: rtl/ora_and_sisr.sv
// Output response analyser for the AND-gate BIST loop: compacts CUT responses
// into a SISR, counts direct mismatches and reports done/pass.
module ora_and_sisr
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY     = POLY_DEF,
  parameter logic [SIG_W-1:0] SIG_INIT = '0,
  parameter int unsigned      CNT_W    = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  ora_and_sisr_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, num_q, err_q, cnt_inc;
  logic             done_q, pass_q;
  logic             sample, mismatch;
  logic [SIG_W-1:0] sig;

  // start wins over everything, so a pat_valid in the start cycle never samples
  assign sample   = (state_q == RUN) && bus.pat_valid && !bus.start;
  assign mismatch = bus.cut_out != and_gold(bus.pat);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  sisr_reg #(
    .SIG_W   (SIG_W),
    .POLY    (POLY),
    .SIG_INIT(SIG_INIT)
  ) u_sisr (
    .clk  (clk),
    .rst  (rst),
    .clear(bus.start),
    .shift(sample),
    .din  (bus.cut_out),
    .sig  (sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = (bus.num_pat == '0) ? CHECK : RUN;
    end else begin
      unique case (state_q)
        RUN:     if (sample && cnt_inc == num_q) state_d = CHECK;
        CHECK:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      num_q  <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (bus.start) begin
      cnt_q  <= '0;
      num_q  <= bus.num_pat;
      err_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      if (sample) begin
        cnt_q <= cnt_inc;
        if (mismatch && err_q != '1) err_q <= err_q + CNT_W'(1);
      end
      if (state_q == CHECK) begin
        pass_q <= (sig == bus.golden_sig) && (err_q == '0);
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == CHECK);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_ora_and_sisr.sv
// Bench for ora_and_sisr: directed scenarios plus randomized sessions, all
// checked every cycle against a session-level behavioural model.
module tb_ora_and_sisr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ora_and_sisr_if #(.SIG_W(8), .CNT_W(4)) bus ();

  ora_and_sisr #(
    .SIG_W(8), .POLY(8'h1D), .SIG_INIT(8'h00), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int idx  = 0;
  int mode = 0;  // 0 fault-free, 1 stuck-at-0, 2 stuck-at-1, 3 random response

  // Behavioural model: a session is "samples left", then one check cycle.
  int  m_sig, m_err, m_left;
  bit  m_active, m_check, m_done, m_pass;
  bit  cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiply by x modulo x^8+x^4+x^3+x^2+1, then add the serial bit.
  function automatic int sisr_step(input int s, input int bit_in);
    int r;
    r = s * 2;
    if (r > 255) r = (r - 256) ^ 'h1D;
    return r ^ bit_in;
  endfunction

  function automatic int good_sig(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s = sisr_step(s, (seq[i % 4] == 2'b11) ? 1 : 0);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sig = 0; m_err = 0; m_left = 0;
      m_active = 0; m_check = 0; m_done = 0; m_pass = 0;
    end else if (bus.start) begin
      m_sig = 0; m_err = 0; m_left = int'(bus.num_pat);
      m_done = 0; m_pass = 0;
      m_active = (m_left != 0);
      m_check  = (m_left == 0);
    end else if (m_check) begin
      m_pass  = (m_sig == int'(bus.golden_sig)) && (m_err == 0);
      m_done  = 1;
      m_check = 0;
    end else if (m_active && bus.pat_valid) begin
      m_sig = sisr_step(m_sig, int'(bus.cut_out));
      if ((bus.cut_out == 1'b1) != (bus.pat == 2'b11) && m_err < 15) m_err++;
      m_left--;
      if (m_left == 0) begin
        m_active = 0;
        m_check  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("signature", bus.signature, m_sig);
      check("err_cnt", bus.err_cnt, m_err);
      check("busy", bus.busy, m_active || m_check);
      check("done", bus.done, m_done);
      if (m_done) check("pass", bus.pass, m_pass);
    end
  end

  function automatic logic cut_for(input logic [1:0] p);
    case (mode)
      0:       return p[1] & p[0];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return logic'($urandom % 2);
    endcase
  endfunction

  // One clock: drive inputs, take the edge, return 1 time unit after it.
  task automatic cyc(input bit v, input bit s);
    bus.start     = s;
    bus.pat_valid = v;
    bus.pat       = seq[idx];
    bus.cut_out   = cut_for(seq[idx]);
    @(posedge clk);
    #1;
    if (v) idx = (idx + 1) % 4;
  endtask

  task automatic begin_session(input int n, input logic [7:0] g, input bit v);
    bus.num_pat    = 4'(n);
    bus.golden_sig = g;
    cyc(v, 1'b1);
    idx = 0;
  endtask

  task automatic expect_result(input string name, input int sig, input int err, input bit pass);
    check({name, "_sig"}, bus.signature, sig);
    check({name, "_model_sig"}, m_sig, sig);
    check({name, "_err"}, bus.err_cnt, err);
    check({name, "_model_err"}, m_err, err);
    check({name, "_done"}, bus.done, 1);
    check({name, "_pass"}, bus.pass, pass);
  endtask

  initial begin
    bus.start = 0; bus.pat = 0; bus.cut_out = 0; bus.pat_valid = 0;
    bus.num_pat = 0; bus.golden_sig = 0;
    rst = 1'b1;
    #2;
    check("rst_sig", bus.signature, 0);
    check("rst_err", bus.err_cnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc(0, 0);

    // fault-free, with done latency
    mode = 0;
    begin_session(4, 8'h02, 0);
    repeat (4) cyc(1, 0);
    check("s1_done_after_1_edge", bus.done, 0);
    cyc(0, 0);
    expect_result("s1", 8'h02, 0, 1);

    mode = 1;
    begin_session(4, 8'h02, 0);
    repeat (4) cyc(1, 0);
    repeat (2) cyc(0, 0);
    expect_result("sa0", 8'h00, 1, 0);

    mode = 2;
    begin_session(4, 8'h02, 0);
    repeat (4) cyc(1, 0);
    repeat (2) cyc(0, 0);
    expect_result("sa1", 8'h0F, 3, 0);

    // gapped valid; start-cycle valid ignored; DONE ignores valid
    mode = 0;
    begin_session(4, 8'h02, 1);
    foreach (seq[i]) begin end
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    cyc(0, 0);
    expect_result("gap", 8'h02, 0, 1);
    cyc(1, 0); cyc(1, 0);
    expect_result("gap_hold", 8'h02, 0, 1);

    // restart mid-session
    mode = 2;
    begin_session(4, 8'h02, 0);
    cyc(1, 0); cyc(1, 0);
    check("restart_pre_sig", bus.signature, 8'h03);
    mode = 0;
    begin_session(4, 8'h02, 0);
    check("restart_sig_clear", bus.signature, 0);
    check("restart_err_clear", bus.err_cnt, 0);
    check("restart_busy", bus.busy, 1);
    repeat (4) cyc(1, 0);
    cyc(0, 0);
    expect_result("restart", 8'h02, 0, 1);

    // empty session
    begin_session(0, 8'h00, 0);
    check("np0_done_early", bus.done, 0);
    cyc(0, 0);
    expect_result("np0", 8'h00, 0, 1);

    // async reset mid-run
    mode = 2;
    begin_session(4, 8'h00, 0);
    cyc(1, 0); cyc(1, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_sig", bus.signature, 0);
    check("arst_err", bus.err_cnt, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 0);
    check("arst_idle_busy", bus.busy, 0);

    // randomized sessions
    for (int k = 0; k < 60; k++) begin
      int n;
      bit predicted;
      logic [7:0] g;
      n = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      predicted = (mode == 0) && ($urandom % 2 == 1);
      g = predicted ? 8'(good_sig(n)) : 8'($urandom);
      begin_session(n, g, $urandom % 2 == 1);
      if (k % 7 == 3 && n > 1) begin
        cyc(1, 0);
        begin_session(n, g, 0);
      end
      for (int c = 0; c < 200 && !bus.done; c++) cyc($urandom % 3 != 0, 0);
      check("rand_session_done", bus.done, 1);
      if (predicted) check("rand_pass", bus.pass, 1);
      repeat ($urandom_range(0, 3)) cyc($urandom % 2 == 1, 0);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
